// File: rtl/jfq_pkg.sv
// jfq_pkg: shared types and width constants for the prepaid billing meter.
//   call_type_e : line call type (none / local / long-distance / special)
//   state_e     : billing FSM states
//   MONEY_W     : balance width (0.1-unit steps)
//   TIME_W      : call-minute counter width
package jfq_pkg;

    localparam int MONEY_W = 11;
    localparam int TIME_W  = 9;

    typedef enum logic [1:0] {
        TYPE_NONE    = 2'b00,
        TYPE_LOCAL   = 2'b01,
        TYPE_LONG    = 2'b10,
        TYPE_SPECIAL = 2'b11
    } call_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TALK = 2'b01,
        ST_CUT  = 2'b10
    } state_e;

endpackage

// File: rtl/jfq_minute_tick.sv
// jfq_minute_tick: wrap counter 0..MIN_CYCLES-1 producing a one-cycle minute tick.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (call start); suppresses the tick
//   en         : count enable (call in progress and not cut)
//   tick       : high in the cycle the counter sits at MIN_CYCLES-1 while enabled;
//                the counter wraps to 0 on that same edge
module jfq_minute_tick #(
    parameter int MIN_CYCLES = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (MIN_CYCLES > 1) ? $clog2(MIN_CYCLES) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    assign tick = en && !clr && (count_q == CNT_W'(MIN_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/jfq_billing.sv
// jfq_billing: per-call prepaid telephone billing meter.
//   clk, rst_n : clock, asynchronous active-low reset
//   calling    : line off-hook (call in progress)
//   call_type  : call type, sampled at call start (00 none, 01 local, 10 long, 11 special)
//   outtime    : minutes of the current / last call (saturates at 511)
//   outmoney   : remaining balance in 0.1-unit steps, never underflows
//   write      : one-cycle write-back strobe, cycle after calling is sampled low
//   warn       : outmoney < WARN_LEVEL
//   cut        : forced disconnect, held until calling falls
// The first minute is billed on the start edge; each following minute is billed
// every MIN_CYCLES cycles while talking.
module jfq_billing
    import jfq_pkg::*;
#(
    parameter int MIN_CYCLES   = 60,
    parameter int INIT_BALANCE = 1000,
    parameter int RATE_LOCAL   = 3,
    parameter int RATE_LONG    = 6,
    parameter int WARN_LEVEL   = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               calling,
    input  logic [2:1]         call_type,
    output logic [TIME_W-1:0]  outtime,
    output logic [MONEY_W-1:0] outmoney,
    output logic               write,
    output logic               warn,
    output logic               cut
);

    function automatic logic [MONEY_W-1:0] rate_of(input call_type_e t);
        case (t)
            TYPE_LOCAL: return MONEY_W'(RATE_LOCAL);
            TYPE_LONG:  return MONEY_W'(RATE_LONG);
            default:    return '0;
        endcase
    endfunction

    state_e             state_q, state_d;
    call_type_e         type_q, type_d;
    logic               calling_q;
    logic [TIME_W-1:0]  outtime_q, outtime_d;
    logic [MONEY_W-1:0] outmoney_q, outmoney_d;
    logic               write_q, write_d;
    logic               cut_q, cut_d;

    logic               start, stop, tick, tick_en, afford;
    call_type_e         sel_type;
    logic [MONEY_W-1:0] rate;

    assign start = calling && !calling_q;
    assign stop  = !calling && calling_q;

    // On the start edge the rate comes from the freshly sampled type.
    assign sel_type = start ? call_type_e'(call_type) : type_q;
    assign rate     = rate_of(sel_type);
    assign afford   = (outmoney_q >= rate);
    assign tick_en  = (state_q == ST_TALK) && calling && !start;

    jfq_minute_tick #(
        .MIN_CYCLES(MIN_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        outtime_d  = outtime_q;
        outmoney_d = outmoney_q;
        cut_d      = cut_q;
        write_d    = stop;
        if (start) begin
            type_d = call_type_e'(call_type);
            if (afford) begin
                outmoney_d = outmoney_q - rate;
                outtime_d  = TIME_W'(1);
                cut_d      = 1'b0;
                state_d    = ST_TALK;
            end else begin
                outtime_d = '0;
                cut_d     = 1'b1;
                state_d   = ST_CUT;
            end
        end else if (stop) begin
            cut_d   = 1'b0;
            state_d = ST_IDLE;
        end else if (tick) begin
            if (afford) begin
                outmoney_d = outmoney_q - rate;
                if (outtime_q != '1) begin
                    outtime_d = outtime_q + 1'b1;
                end
            end else begin
                cut_d   = 1'b1;
                state_d = ST_CUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            type_q     <= TYPE_NONE;
            calling_q  <= 1'b0;
            outtime_q  <= '0;
            outmoney_q <= MONEY_W'(INIT_BALANCE);
            write_q    <= 1'b0;
            cut_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            calling_q  <= calling;
            outtime_q  <= outtime_d;
            outmoney_q <= outmoney_d;
            write_q    <= write_d;
            cut_q      <= cut_d;
        end
    end

    assign outtime  = outtime_q;
    assign outmoney = outmoney_q;
    assign write    = write_q;
    assign cut      = cut_q;
    assign warn     = (outmoney_q < MONEY_W'(WARN_LEVEL));

endmodule

// File: tb/tb_jfq_billing.sv
// tb_jfq_billing: bench for jfq_billing. Instance a uses the default tariff
// (MIN_CYCLES=60, balance 1000); instance b uses MIN_CYCLES=4, balance 35 to
// reach exhaustion quickly. Inputs are driven and outputs sampled 1 time unit
// after each rising edge.
module tb_jfq_billing;
  import jfq_pkg::*;

  localparam int MIN_A = 60;
  localparam int MIN_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic calling_a, calling_b;
  logic [1:0] type_a, type_b;
  logic [TIME_W-1:0] time_a, time_b;
  logic [MONEY_W-1:0] money_a, money_b;
  logic write_a, write_b, warn_a, warn_b, cut_a, cut_b;

  jfq_billing #(.MIN_CYCLES(MIN_A), .INIT_BALANCE(1000)) dut_a (
    .clk(clk), .rst_n(rst_n), .calling(calling_a), .call_type(type_a),
    .outtime(time_a), .outmoney(money_a), .write(write_a), .warn(warn_a), .cut(cut_a)
  );

  jfq_billing #(.MIN_CYCLES(MIN_B), .INIT_BALANCE(35)) dut_b (
    .clk(clk), .rst_n(rst_n), .calling(calling_b), .call_type(type_b),
    .outtime(time_b), .outmoney(money_b), .write(write_b), .warn(warn_b), .cut(cut_b)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: a call held for n edges wants 1 + (n-1)/MIN minutes; the
  // account can pay for bal/rate of them; free calls never run out.
  task automatic model_call(input int bal, input int t, input int n,
                            output int et, output int em, output int ec);
    int rate, want, paid;
    rate = (t == 1) ? 3 : (t == 2) ? 6 : 0;
    want = 1 + (n - 1) / MIN_A;
    if (rate == 0) paid = want;
    else paid = (bal / rate < want) ? bal / rate : want;
    et = (paid > 511) ? 511 : paid;
    em = bal - paid * rate;
    ec = (paid < want) ? 1 : 0;
  endtask

  task automatic run_call_a(input logic [1:0] t, input logic [1:0] mid, input int n,
                            input int exp_time, input int exp_money, input int exp_cut);
    calling_a = 1'b1;
    type_a = t;
    for (int k = 0; k < n; k++) begin
      tick_n(1);
      if (k == 0) type_a = mid;
    end
    check("call_time", int'(time_a), exp_time);
    check("call_money", int'(money_a), exp_money);
    check("call_cut", int'(cut_a), exp_cut);
    calling_a = 1'b0;
    type_a = 2'b00;
    tick_n(1);
    check("end_write", int'(write_a), 1);
    check("end_cut", int'(cut_a), 0);
    check("hold_time", int'(time_a), exp_time);
    check("hold_money", int'(money_a), exp_money);
    tick_n(1);
    check("write_once", int'(write_a), 0);
  endtask

  typedef struct {
    logic [1:0] ctype;
    logic [1:0] mid_type;
    int ncyc;
    int exp_time;
    int exp_money;
  } vec_t;

  vec_t vecs[4];
  int model_money;
  int et, em, ec;
  int rt, rn;

  initial begin
    vecs[0] = '{2'b10, 2'b01, 20, 1, 988};   // long, type change mid-call ignored
    vecs[1] = '{2'b11, 2'b11, 130, 3, 988};  // special: minutes but no charge
    vecs[2] = '{2'b00, 2'b00, 61, 2, 988};   // none behaves as free call
    vecs[3] = '{2'b01, 2'b01, 1, 1, 985};    // one-cycle local call still billed

    rst_n = 1'b0;
    calling_a = 1'b0;
    calling_b = 1'b0;
    type_a = 2'b00;
    type_b = 2'b00;
    tick_n(3);
    check("rst_money", int'(money_a), 1000);
    check("rst_time", int'(time_a), 0);
    check("rst_write", int'(write_a), 0);
    check("rst_warn", int'(warn_a), 0);
    check("rst_cut", int'(cut_a), 0);
    check("rst_money_b", int'(money_b), 35);
    rst_n = 1'b1;
    tick_n(10);
    check("idle_money", int'(money_a), 1000);
    check("idle_time", int'(time_a), 0);
    check("idle_write", int'(write_a), 0);

    // Local call, 65 cycles with minute-boundary checks.
    calling_a = 1'b1;
    type_a = 2'b01;
    tick_n(1);
    check("loc_first_time", int'(time_a), 1);
    check("loc_first_money", int'(money_a), 997);
    tick_n(59);
    check("loc_pre_min_time", int'(time_a), 1);
    check("loc_pre_min_money", int'(money_a), 997);
    tick_n(1);
    check("loc_min2_time", int'(time_a), 2);
    check("loc_min2_money", int'(money_a), 994);
    tick_n(4);
    calling_a = 1'b0;
    check("loc_prewrite", int'(write_a), 0);
    tick_n(1);
    check("loc_write", int'(write_a), 1);
    check("loc_hold_time", int'(time_a), 2);
    check("loc_hold_money", int'(money_a), 994);
    tick_n(1);
    check("loc_write_once", int'(write_a), 0);
    tick_n(3);

    for (int i = 0; i < 4; i++) begin
      run_call_a(vecs[i].ctype, vecs[i].mid_type, vecs[i].ncyc,
                 vecs[i].exp_time, vecs[i].exp_money, 0);
      tick_n(2);
    end

    model_money = 985;
    for (int i = 0; i < 8; i++) begin
      rt = $urandom_range(0, 3);
      rn = $urandom_range(1, 150);
      model_call(model_money, rt, rn, et, em, ec);
      run_call_a(rt[1:0], rt[1:0], rn, et, em, ec);
      model_money = em;
      tick_n($urandom_range(1, 3));
    end

    // Exhaustion on instance b: 35 -> 32, 29, ..., 2 over 11 minutes.
    calling_b = 1'b1;
    type_b = 2'b01;
    tick_n(1);
    check("ex_m1_money", int'(money_b), 32);
    check("ex_m1_warn", int'(warn_b), 0);
    tick_n(4);
    check("ex_m2_money", int'(money_b), 29);
    check("ex_m2_warn", int'(warn_b), 1);
    tick_n(39);
    check("ex_last_time", int'(time_b), 11);
    check("ex_last_money", int'(money_b), 2);
    check("ex_last_cut", int'(cut_b), 0);
    tick_n(1);
    check("ex_cut", int'(cut_b), 1);
    check("ex_cut_time", int'(time_b), 11);
    check("ex_cut_money", int'(money_b), 2);
    tick_n(5);
    check("ex_cut_hold", int'(cut_b), 1);
    check("ex_cut_hold_time", int'(time_b), 11);
    calling_b = 1'b0;
    tick_n(1);
    check("ex_end_cut", int'(cut_b), 0);
    check("ex_end_write", int'(write_b), 1);
    tick_n(2);
    calling_b = 1'b1;
    tick_n(1);
    check("ex_start_cut", int'(cut_b), 1);
    check("ex_start_time", int'(time_b), 0);
    check("ex_start_money", int'(money_b), 2);
    tick_n(8);
    check("ex_start_cut_hold", int'(cut_b), 1);
    calling_b = 1'b0;
    tick_n(1);
    check("ex_start_write", int'(write_b), 1);
    tick_n(2);
    // Special call at balance 2 never cuts.
    calling_b = 1'b1;
    type_b = 2'b11;
    tick_n(10);
    check("sp_low_time", int'(time_b), 3);
    check("sp_low_money", int'(money_b), 2);
    check("sp_low_cut", int'(cut_b), 0);
    calling_b = 1'b0;
    tick_n(2);

    // Reset in the middle of a local call.
    calling_a = 1'b1;
    type_a = 2'b01;
    tick_n(10);
    rst_n = 1'b0;
    #1;
    check("mr_money", int'(money_a), 1000);
    check("mr_time", int'(time_a), 0);
    check("mr_cut", int'(cut_a), 0);
    check("mr_write", int'(write_a), 0);
    check("mr_money_b", int'(money_b), 35);
    calling_a = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick_n(1);
      check("mr_no_write", int'(write_a), 0);
    end
    check("mr_after_money", int'(money_a), 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jfq_billing.md
Name: jfq_billing

Overview:
- Per-call telephone billing meter for a prepaid account.
- Tracks the remaining balance and the minutes of the current call.
- Deducts a per-minute tariff selected by call type.
- Raises a low-balance warning, cuts the call when the balance cannot cover the next minute, and pulses a write-back strobe when a call ends.

Parameters:
- MIN_CYCLES, 60, clock cycles per billed minute (set small in simulation).
- INIT_BALANCE, 1000, balance loaded at reset, in 0.1-unit steps (1000 = 100.0).
- RATE_LOCAL, 3, deduction per minute for type 01.
- RATE_LONG, 6, deduction per minute for type 10.
- WARN_LEVEL, 30, warn threshold; warn is asserted while balance < WARN_LEVEL.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- calling  in  1  high while the line is off-hook (call in progress).
- type  in  2 ([2:1])  call type: 00 none, 01 local, 10 long-distance, 11 special (free).
- outtime  out  9  minutes of the current or last call.
- outmoney  out  11  remaining balance.
- write  out  1  one-cycle pulse at call end (write-back strobe).
- warn  out  1  low-balance indicator.
- cut  out  1  forced disconnect indicator.

Behaviour:
- Reset (async, rst_n=0):
  - outmoney=INIT_BALANCE; outtime=0; write=0; warn=0; cut=0.
  - Cycle counter=0; latched type=00; calling edge register=0.
- Edges: calling is registered each cycle. Start = calling=1 and previous=0. End = calling=0 and previous=1.
- Rate by latched type: 01 -> RATE_LOCAL, 10 -> RATE_LONG, 11 -> 0, 00 -> 0.
- Call start cycle:
  - Latch type; it is ignored mid-call.
  - Clear the cycle counter and cut.
  - Bill the first minute immediately, using the rate of the newly sampled type:
    - If outmoney >= rate: outmoney -= rate and outtime = 1.
    - Otherwise: cut=1, outtime=0, no deduction.
- In call (calling=1, cut=0):
  - The cycle counter increments each clock.
  - When it reaches MIN_CYCLES-1 it wraps to 0 and the next minute is billed under the same affordability rule:
    - Affordable: deduct the rate and increment outtime, saturating at 511.
    - Not affordable: cut=1, no deduction, outtime holds.
- Once cut=1:
  - Counting and billing stop.
  - cut holds until calling falls, and is cleared on the end cycle.
- Call end:
  - write=1 for exactly one cycle, on the cycle after calling is sampled low.
  - outtime and outmoney hold their final values until the next call start.
- warn: combinational/registered, equal to (outmoney < WARN_LEVEL), valid whether or not a call is active.
- outmoney never underflows.
- Special type (11) counts minutes but never deducts and never cuts.
- Type 00 with calling=1 behaves as a free call.
- Start and end cannot coincide (single input).
- Reset mid-call aborts the call immediately, restores INIT_BALANCE and produces no write pulse.

Decomposition:
- Shared package jfq_pkg holds:
  - A call-type enum: TYPE_NONE=2'b00, TYPE_LOCAL=2'b01, TYPE_LONG=2'b10, TYPE_SPECIAL=2'b11.
  - Width constants: MONEY_W=11, TIME_W=9.
- One natural sub-module, jfq_minute_tick: a MIN_CYCLES-1 wrap counter with sync clear, producing a one-cycle minute tick.
- Billing and FSM logic stay in the top-level module.
- FSM states: IDLE, TALK, CUT.

Test Plan:
- Reset (defaults): hold rst_n=0 -> outmoney=1000, outtime=0, write=warn=cut=0. Release and idle 10 cycles -> outputs unchanged.
- Local call (MIN_CYCLES=60): calling=1, type=01 for 65 cycles.
  - Expect outtime=1 and outmoney=997 after the start cycle.
  - Expect outtime=2 and outmoney=994 at cycle 60.
  - Drop calling -> write high exactly one cycle; outputs hold 2 and 994.
- Long-distance call: from 994, calling=1, type=10 for 20 cycles -> outtime=1, outmoney=988; write pulse at end. Changing type mid-call to 01 has no effect on the rate.
- Special call: type=11 for 130 cycles -> outtime=3, outmoney unchanged, cut=0.
- Exhaustion (INIT_BALANCE=35, MIN_CYCLES=4): local call.
  - Balance steps 32, 29 (warn=1 from here), ..., 2 after 11 minutes.
  - At the 12th minute boundary cut=1, outtime=11, outmoney=2.
  - Drop calling -> cut=0, write pulse.
  - A new local call sets cut=1 on its start cycle, with outtime=0.
- Reset mid-call: assert rst_n=0 during a local call -> all outputs return to reset values asynchronously, with no write pulse.
